mul_rr_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one 32x32 shift-add multiplier among NREQ requesters.

---
 rtl/mul_rr_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mul_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter
//   Round-robin arbiter/sequencer that shares one multi-cycle 32x32 multiplier
//   among NREQ requesters. It grants one requester and latches that requester's
//   operands onto the multiplier. It holds mul_start high for MUL_LAT cycles
//   and then captures the 64-bit product. The product goes back to the winner
//   with a one-cycle res_valid pulse. mul_start is then held low long enough
//   for the multiplier to re-arm.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   req        in   NREQ     per-requester request level
//   ain_flat   in   NREQ*32  operand A, requester i at [32*i+31:32*i]
//   bin_flat   in   NREQ*32  operand B, same packing
//   gnt        out  NREQ     one-hot, high while requester i's op is in flight
//   res_valid  out  NREQ     one-cycle pulse to the winner when res is valid
//   res        out  64       last captured product, held until next capture
//   busy       out  1        high whenever the sequencer is not idle
//   mul_start  out  1        start level to the multiplier
//   mul_ain    out  32       operand A to the multiplier
//   mul_bin    out  32       operand B to the multiplier
//   mul_yout   in   64       product from the multiplier

module mul_rr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MUL_LAT   = 34,
  parameter int unsigned REARM_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   ain_flat,
  input  logic [NREQ*32-1:0]   bin_flat,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      res_valid,
  output logic [63:0]          res,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_ain,
  output logic [31:0]          mul_bin,
  input  logic [63:0]          mul_yout
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_MAX = (MUL_LAT > REARM_CYC) ? MUL_LAT : REARM_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SUM_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LAST_REARM = CNT_W'(REARM_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REARM = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]    gnt_d;
  logic [NREQ-1:0]    res_valid_d;
  logic [63:0]        res_d;
  logic               busy_d;
  logic               mul_start_d;
  logic [31:0]        mul_ain_d;
  logic [31:0]        mul_bin_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   win_next;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   nxt_sum;
  logic [PTR_W-1:0]   cand;

  // Operand slices unpacked per requester so the winner can index them directly.
  logic [31:0]        ain_arr [NREQ];
  logic [31:0]        bin_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ain_arr[g] = ain_flat[32*g +: 32];
    assign bin_arr[g] = bin_flat[32*g +: 32];
  end

  // Round-robin search: first set req bit starting at ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(NREQ)) begin
        sum = sum - SUM_W'(NREQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Pointer to load after a grant: one past the winner, wrapping.
  always_comb begin
    nxt_sum  = {1'b0, win} + SUM_W'(1);
    win_next = nxt_sum[PTR_W-1:0];
    if (nxt_sum >= SUM_W'(NREQ)) begin
      win_next = '0;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt;
    res_valid_d = '0;
    res_d       = res;
    busy_d      = busy;
    mul_start_d = mul_start;
    mul_ain_d   = mul_ain;
    mul_bin_d   = mul_bin;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = NREQ'(1) << win;
          mul_ain_d   = ain_arr[win];
          mul_bin_d   = bin_arr[win];
          mul_start_d = 1'b1;
          cnt_d       = '0;
          busy_d      = 1'b1;
          ptr_d       = win_next;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (cnt_q == LAST_ISSUE) begin
          // gnt still marks the winner here, so it doubles as the response mask.
          res_d       = mul_yout;
          res_valid_d = gnt;
          gnt_d       = '0;
          mul_start_d = 1'b0;
          cnt_d       = '0;
          state_d     = REARM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      REARM: begin
        if (cnt_q == LAST_REARM) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        gnt_d       = '0;
        mul_start_d = 1'b0;
        cnt_d       = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      res_valid <= '0;
      res       <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_ain   <= '0;
      mul_bin   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      res_valid <= res_valid_d;
      res       <= res_d;
      busy      <= busy_d;
      mul_start <= mul_start_d;
      mul_ain   <= mul_ain_d;
      mul_bin   <= mul_bin_d;
    end
  end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Testbench for mul_rr_arbiter with a behavioural fixed-latency multiplier
// and a round-robin reference model kept as a plain integer pointer.

module tb_mul_rr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned MUL_LAT   = 34;
  localparam int unsigned REARM_CYC = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   ain_flat;
  logic [NREQ*32-1:0]   bin_flat;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      res_valid;
  logic [63:0]          res;
  logic                 busy;
  logic                 mul_start;
  logic [31:0]          mul_ain;
  logic [31:0]          mul_bin;
  logic [63:0]          mul_yout = '0;

  logic [31:0]          a_v [NREQ];
  logic [31:0]          b_v [NREQ];

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int mcnt   = 0;

  mul_rr_arbiter #(
    .NREQ      (NREQ),
    .MUL_LAT   (MUL_LAT),
    .REARM_CYC (REARM_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ain_flat  (ain_flat),
    .bin_flat  (bin_flat),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res       (res),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_ain   (mul_ain),
    .mul_bin   (mul_bin),
    .mul_yout  (mul_yout)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign ain_flat[32*g +: 32] = a_v[g];
    assign bin_flat[32*g +: 32] = b_v[g];
  end

  // Multiplier: output reads 0 until start has been high MUL_LAT cycles at capture.
  always @(posedge clk) begin
    if (!mul_start) begin
      mcnt     <= 0;
      mul_yout <= '0;
    end else begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 >= int'(MUL_LAT) - 1) mul_yout <= 64'(mul_ain) * 64'(mul_bin);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_gnt"},       64'(gnt),       0);
    chk({pfx, "_res_valid"}, 64'(res_valid), 0);
    chk({pfx, "_res"},       res,            0);
    chk({pfx, "_busy"},      64'(busy),      0);
    chk({pfx, "_mul_start"}, 64'(mul_start), 0);
    chk({pfx, "_mul_ain"},   64'(mul_ain),   0);
    chk({pfx, "_mul_bin"},   64'(mul_bin),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 0);
  endtask

  // One operation: predict the winner from the current req level and the model
  // pointer, then check grant, operands, latency and product. Ends on the
  // negedge where res_valid is visible. b2b checks the re-grant gap from the
  // previous res_valid; chg_at>0 rewrites the winner's operands and drops its
  // req that many cycles into the operation.
  task automatic do_op(input bit b2b, input int chg_at);
    int               w, j, n, lows;
    logic [31:0]      ea, eb;
    logic [63:0]      ep;
    logic [NREQ-1:0]  oh;
    w = -1;
    for (int i = 0; i < int'(NREQ); i++) begin
      j = (m_ptr + i) % int'(NREQ);
      if (w < 0 && req[j]) w = j;
    end
    if (w < 0) return;
    ea = a_v[w];
    eb = b_v[w];
    ep = 64'(ea) * 64'(eb);
    oh = NREQ'(1) << w;

    n = 0;
    lows = 0;
    while (gnt == '0 && n < 200) begin
      if (!mul_start) lows++;
      if (b2b && n == 1) chk("rv_clear", 64'(res_valid), 0);
      @(negedge clk);
      n++;
    end
    chk("gnt_timeout", 64'(n < 200), 1);
    if (b2b) begin
      chk("regrant_gap", 64'(n), 64'(REARM_CYC + 1));
      chk("start_low_run", 64'(lows), 64'(REARM_CYC + 1));
    end
    chk("gnt", 64'(gnt), 64'(oh));
    chk("mul_ain", 64'(mul_ain), 64'(ea));
    chk("mul_bin", 64'(mul_bin), 64'(eb));
    chk("mul_start", 64'(mul_start), 1);
    chk("busy", 64'(busy), 1);
    m_ptr = (w + 1) % int'(NREQ);

    n = 0;
    while (res_valid == '0 && n < int'(MUL_LAT) + 20) begin
      @(negedge clk);
      n++;
      if (n == chg_at) begin
        a_v[w] = $urandom;
        b_v[w] = $urandom;
        req[w] = 1'b0;
      end
    end
    chk("latency", 64'(n), 64'(MUL_LAT));
    chk("res_valid", 64'(res_valid), 64'(oh));
    chk("res", res, ep);
    chk("gnt_clear", 64'(gnt), 0);
    chk("start_clear", 64'(mul_start), 0);
  endtask

  initial begin
    int          pulses;
    int          n;
    logic [63:0] pa;

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    m_ptr = 0;

    // Single op with known product.
    a_v[0] = 32'd89;
    b_v[0] = 32'd33;
    req = 4'b0001;
    do_op(1'b0, -1);
    chk("single_res", res, 64'hB79);
    req = '0;
    wait_idle();

    // Two simultaneous requesters from ptr=0, then verify ptr moved to 3.
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    req = 4'b0101;
    do_op(1'b0, -1);
    do_op(1'b1, -1);
    req = '0;
    wait_idle();
    req = 4'b1111;
    do_op(1'b0, -1);
    req = '0;
    wait_idle();

    // All requesters held: rotation across eight back-to-back ops.
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) do_op(k > 0, -1);
    req = '0;
    wait_idle();

    // Operand extremes.
    a_v[1] = 32'hFFFF_FFFF;
    b_v[1] = 32'hFFFF_FFFF;
    req = 4'b0010;
    do_op(1'b0, -1);
    chk("max_res", res, 64'hFFFF_FFFE_0000_0001);
    req = '0;
    wait_idle();
    a_v[3] = 32'd0;
    b_v[3] = $urandom | 32'h1;
    req = 4'b1000;
    do_op(1'b0, -1);
    chk("zero_res", res, 64'd0);
    req = '0;
    wait_idle();

    // Reset in the middle of an operation: grant 2 moves ptr to 3, reset restores 0.
    do_reset();
    a_v[2] = $urandom;
    b_v[2] = $urandom;
    req = 4'b0100;
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_gnt_seen", 64'(gnt), 64'(4'b0100));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midop_rst");
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    pulses = 0;
    repeat (MUL_LAT + 5) begin
      @(negedge clk);
      if (res_valid != '0) pulses++;
    end
    chk("no_rv_after_rst", 64'(pulses), 0);
    for (int i = 0; i < int'(NREQ); i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    req = 4'b1010;
    do_op(1'b0, -1);
    req = '0;
    wait_idle();

    // Operand change and req drop mid-operation.
    a_v[2] = $urandom;
    b_v[2] = $urandom;
    pa = 64'(a_v[2]) * 64'(b_v[2]);
    req = 4'b0100;
    do_op(1'b0, 5);
    chk("chg_res", res, pa);
    pulses = 0;
    repeat (MUL_LAT) begin
      @(negedge clk);
      if (res_valid != '0) pulses++;
    end
    chk("chg_single_pulse", 64'(pulses), 0);
    chk("chg_res_hold", res, pa);
    wait_idle();

    // Random request patterns and operands.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        a_v[i] = (k % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
        b_v[i] = $urandom;
      end
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_op(1'b0, -1);
    end
    req = '0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
